// File: rtl/cu_multi.sv
// cu_multi - multi-cycle control unit for the accumulator processor.
//
// Decodes the IR opcode field and sequences FETCH -> DECODE -> execute for
// LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS, HALT, JMP, JNZ, LDI and NOP.
// Every memory access (FETCH, LOAD, STORE) holds until i_memrdy. The unit
// counts retired instructions, which are execute states that return to
// FETCH.
//
// Optional feature macro: CU_IN_TIMEOUT_EN
//   When defined, INPUT gives up after IN_TO cycles without i_enter. It then
//   pulses o_intimeout, does not load A, and returns to FETCH. When the macro
//   is undefined, INPUT waits forever and o_intimeout is tied to 0.
//
// Parameters:
//   OP_W   opcode width (3 or 4); with 3 only opcodes 0-7 exist
//   CNT_W  width of the retired-instruction counter (wraps)
//   IN_TO  INPUT timeout in cycles (only with CU_IN_TIMEOUT_EN)
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          asynchronous active-high reset, returns the unit to START
//   i_ir           opcode field of IR
//   i_aeq0/i_apos  A == 0 / A > 0 flags
//   i_enter        input-port data valid
//   i_memrdy       memory completed the current access this cycle
//   o_irload, o_pcload, o_jmpmux, o_meminst, o_memreq, o_memwr,
//   o_aload, o_sub, o_asel[1:0]   datapath/memory controls
//                  o_asel: 00 ALU, 01 input port, 10 memory, 11 IR immediate
//   o_halt, o_illegal, o_intimeout  status outputs
//   o_inst_count   retired-instruction count
//   o_state        current state; o_nstate is the combinational next state
module cu_multi #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16,
  parameter int IN_TO = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [OP_W-1:0]  i_ir,
  input  logic             i_aeq0,
  input  logic             i_apos,
  input  logic             i_enter,
  input  logic             i_memrdy,
  output logic             o_irload,
  output logic             o_pcload,
  output logic             o_jmpmux,
  output logic             o_meminst,
  output logic             o_memreq,
  output logic             o_memwr,
  output logic             o_aload,
  output logic             o_sub,
  output logic [1:0]       o_asel,
  output logic             o_halt,
  output logic             o_illegal,
  output logic             o_intimeout,
  output logic [CNT_W-1:0] o_inst_count,
  output logic [3:0]       o_state,
  output logic [3:0]       o_nstate
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_JZ     = 4'd8,
    S_JPOS   = 4'd9,
    S_HALT   = 4'd10,
    S_JMP    = 4'd11,
    S_JNZ    = 4'd12,
    S_LDI    = 4'd13,
    S_NOP    = 4'd14,
    S_ILL    = 4'd15
  } state_t;

  state_t            r_state;
  state_t            w_nstate;
  logic [3:0]        w_op;
  logic              w_timeout;
  logic              w_retire;
  logic [CNT_W-1:0]  r_count;

  // A 3-bit opcode zero-extends, so only the first eight entries are reachable.
  assign w_op = 4'(i_ir);

  function automatic state_t decode_op(input logic [3:0] op);
    case (op)
      4'd0:    decode_op = S_LOAD;
      4'd1:    decode_op = S_STORE;
      4'd2:    decode_op = S_ADD;
      4'd3:    decode_op = S_SUB;
      4'd4:    decode_op = S_INPUT;
      4'd5:    decode_op = S_JZ;
      4'd6:    decode_op = S_JPOS;
      4'd7:    decode_op = S_HALT;
      4'd8:    decode_op = S_JMP;
      4'd9:    decode_op = S_JNZ;
      4'd10:   decode_op = S_LDI;
      4'd11:   decode_op = S_NOP;
      default: decode_op = S_ILL;
    endcase
  endfunction

`ifdef CU_IN_TIMEOUT_EN
  localparam int TO_W = (IN_TO < 2) ? 1 : $clog2(IN_TO + 1);
  logic [TO_W-1:0] r_in_cnt;

  // The counter holds the number of Enter-less INPUT cycles already seen.
  // It is cleared whenever the unit is outside INPUT, so it starts at 0 on entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_cnt <= '0;
    end else if (r_state != S_INPUT) begin
      r_in_cnt <= '0;
    end else if (!i_enter) begin
      r_in_cnt <= r_in_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_INPUT) && !i_enter && (r_in_cnt == TO_W'(IN_TO));
`else
  logic w_unused_in_to;
  assign w_unused_in_to = (IN_TO != 0);
  assign w_timeout      = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_START;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate    = r_state;
    o_irload    = 1'b0;
    o_pcload    = 1'b0;
    o_jmpmux    = 1'b0;
    o_meminst   = 1'b0;
    o_memreq    = 1'b0;
    o_memwr     = 1'b0;
    o_aload     = 1'b0;
    o_sub       = 1'b0;
    o_asel      = 2'b00;
    o_halt      = 1'b0;
    o_illegal   = 1'b0;
    o_intimeout = 1'b0;
    case (r_state)
      S_START: w_nstate = S_FETCH;
      S_FETCH: begin
        o_meminst = 1'b1;
        o_memreq  = 1'b1;
        o_irload  = i_memrdy;
        o_pcload  = i_memrdy;
        if (i_memrdy) w_nstate = S_DECODE;
      end
      S_DECODE: begin
        o_meminst = 1'b1;
        w_nstate  = decode_op(w_op);
      end
      S_LOAD: begin
        o_memreq = 1'b1;
        o_asel   = 2'b10;
        o_aload  = i_memrdy;
        if (i_memrdy) w_nstate = S_FETCH;
      end
      S_STORE: begin
        o_memreq = 1'b1;
        o_memwr  = 1'b1;
        if (i_memrdy) w_nstate = S_FETCH;
      end
      S_ADD: begin
        o_aload  = 1'b1;
        w_nstate = S_FETCH;
      end
      S_SUB: begin
        o_aload  = 1'b1;
        o_sub    = 1'b1;
        w_nstate = S_FETCH;
      end
      S_INPUT: begin
        o_asel  = 2'b01;
        o_aload = i_enter;
        // Enter arriving in the timeout cycle wins and performs a normal load.
        if (i_enter) begin
          w_nstate = S_FETCH;
        end else if (w_timeout) begin
          o_intimeout = 1'b1;
          w_nstate    = S_FETCH;
        end
      end
      S_JZ: begin
        o_jmpmux = 1'b1;
        o_pcload = i_aeq0;
        w_nstate = S_FETCH;
      end
      S_JNZ: begin
        o_jmpmux = 1'b1;
        o_pcload = ~i_aeq0;
        w_nstate = S_FETCH;
      end
      S_JPOS: begin
        o_jmpmux = 1'b1;
        o_pcload = i_apos;
        w_nstate = S_FETCH;
      end
      S_JMP: begin
        o_jmpmux = 1'b1;
        o_pcload = 1'b1;
        w_nstate = S_FETCH;
      end
      S_LDI: begin
        o_aload  = 1'b1;
        o_asel   = 2'b11;
        w_nstate = S_FETCH;
      end
      S_NOP:   w_nstate = S_FETCH;
      S_HALT:  o_halt = 1'b1;
      S_ILL: begin
        o_halt    = 1'b1;
        o_illegal = 1'b1;
      end
      default: w_nstate = S_START;
    endcase
  end

  // An instruction retires when an execute state hands back to FETCH. FETCH
  // itself also "goes" to FETCH while waiting, and START enters FETCH once,
  // so both are excluded.
  assign w_retire = (w_nstate == S_FETCH) && (r_state != S_START) && (r_state != S_FETCH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (w_retire) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_inst_count = r_count;
  assign o_state      = r_state;
  assign o_nstate     = w_nstate;

endmodule

// File: tb/tb_cu_multi.sv
`timescale 1ns/1ps
module tb_cu_multi;
  localparam int OP_W     = 4;
  localparam int TB_IN_TO = 3;

  // Expected-output bit positions, in the order of the packed observation below.
  localparam logic [12:0] M_IRL = 13'h1000;
  localparam logic [12:0] M_PCL = 13'h0800;
  localparam logic [12:0] M_JMX = 13'h0400;
  localparam logic [12:0] M_MI  = 13'h0200;
  localparam logic [12:0] M_MR  = 13'h0100;
  localparam logic [12:0] M_MW  = 13'h0080;
  localparam logic [12:0] M_AL  = 13'h0040;
  localparam logic [12:0] M_SUB = 13'h0020;
  localparam logic [12:0] AS_IN = 13'h0008;
  localparam logic [12:0] AS_MEM= 13'h0010;
  localparam logic [12:0] AS_IMM= 13'h0018;
  localparam logic [12:0] M_H   = 13'h0004;
  localparam logic [12:0] M_IL  = 13'h0002;
  localparam logic [12:0] M_TO  = 13'h0001;

  logic            clk = 1'b0;
  logic            rst;
  logic [OP_W-1:0] ir;
  logic            aeq0, apos, enter, memrdy;

  logic irload, pcload, jmpmux, meminst, memreq, memwr, aload, sub;
  logic [1:0] asel;
  logic halt, illegal, intimeout;
  logic [15:0] cnt;
  logic [3:0]  state, nstate;

  logic d4_irload, d4_pcload, d4_jmpmux, d4_meminst, d4_memreq, d4_memwr, d4_aload, d4_sub;
  logic [1:0] d4_asel;
  logic d4_halt, d4_illegal, d4_intimeout;
  logic [3:0] d4_cnt;
  logic [3:0] d4_state, d4_nstate;

  logic [12:0] obs;
  assign obs = {irload, pcload, jmpmux, meminst, memreq, memwr, aload, sub, asel,
                halt, illegal, intimeout};

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt   = 0;

  cu_multi #(.OP_W(OP_W), .CNT_W(16), .IN_TO(TB_IN_TO)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_ir(ir), .i_aeq0(aeq0), .i_apos(apos),
    .i_enter(enter), .i_memrdy(memrdy),
    .o_irload(irload), .o_pcload(pcload), .o_jmpmux(jmpmux), .o_meminst(meminst),
    .o_memreq(memreq), .o_memwr(memwr), .o_aload(aload), .o_sub(sub), .o_asel(asel),
    .o_halt(halt), .o_illegal(illegal), .o_intimeout(intimeout),
    .o_inst_count(cnt), .o_state(state), .o_nstate(nstate)
  );

  cu_multi #(.OP_W(OP_W), .CNT_W(4), .IN_TO(TB_IN_TO)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_ir(ir), .i_aeq0(aeq0), .i_apos(apos),
    .i_enter(enter), .i_memrdy(memrdy),
    .o_irload(d4_irload), .o_pcload(d4_pcload), .o_jmpmux(d4_jmpmux), .o_meminst(d4_meminst),
    .o_memreq(d4_memreq), .o_memwr(d4_memwr), .o_aload(d4_aload), .o_sub(d4_sub),
    .o_asel(d4_asel), .o_halt(d4_halt), .o_illegal(d4_illegal), .o_intimeout(d4_intimeout),
    .o_inst_count(d4_cnt), .o_state(d4_state), .o_nstate(d4_nstate)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Execute state the opcode map selects.
  function automatic int exec_state(input int op);
    int tbl [12] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    if (op >= 0 && op < 12) return tbl[op];
    return 15;
  endfunction

  // Inputs are already driven; sample at the falling edge, then advance one cycle.
  task automatic step(input string tag, input int es, input int ens, input logic [12:0] eo);
    @(negedge clk);
    chk({tag, "/state"},  {28'd0, state},  es);
    chk({tag, "/nstate"}, {28'd0, nstate}, ens);
    chk({tag, "/ctl"},    {19'd0, obs},    {19'd0, eo});
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "/cnt16"}, {16'd0, cnt},   m_cnt % 65536);
    chk({tag, "/cnt4"},  {28'd0, d4_cnt}, m_cnt % 16);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst/state", {28'd0, state}, 0);
    chk("rst/ctl",   {19'd0, obs},   0);
    @(posedge clk);
    #1;
    m_cnt = 0;
    check_counts("rst");
    rst = 1'b0;
    memrdy = 1'b1;
    step("start", 0, 1, '0);
  endtask

  task automatic fetch_decode(input int op, input int fw);
    ir = op[OP_W-1:0];
    check_counts("fetch");
    for (int k = 0; k <= fw; k++) begin
      memrdy = (k == fw);
      enter  = 1'($urandom_range(0, 1));
      step("fetch", 1, (k == fw) ? 2 : 1, M_MI | M_MR | ((k == fw) ? (M_IRL | M_PCL) : 13'd0));
    end
    memrdy = 1'($urandom_range(0, 1));
    enter  = 1'($urandom_range(0, 1));
    step("decode", 2, exec_state(op), M_MI);
  endtask

  task automatic run_instr(input int op, input int fw, input int ew, input bit aq, input bit ap);
    bit done;
    done = 1'b0;
    fetch_decode(op, fw);
    aeq0 = aq;
    apos = ap;
    case (op)
      0, 1: begin
        for (int k = 0; k <= ew; k++) begin
          memrdy = (k == ew);
          if (op == 0)
            step("load", 3, (k == ew) ? 1 : 3, M_MR | AS_MEM | ((k == ew) ? M_AL : 13'd0));
          else
            step("store", 4, (k == ew) ? 1 : 4, M_MR | M_MW);
        end
      end
      4: begin
        for (int k = 0; k <= ew && !done; k++) begin
          enter  = (k == ew);
          memrdy = 1'($urandom_range(0, 1));
`ifdef CU_IN_TIMEOUT_EN
          if (k == TB_IN_TO && k < ew) begin
            step("in_to", 7, 1, AS_IN | M_TO);
            done = 1'b1;
          end else
`endif
          begin
            if (k == ew) step("in", 7, 1, AS_IN | M_AL);
            else         step("in", 7, 7, AS_IN);
          end
        end
      end
      default: begin
        memrdy = 1'($urandom_range(0, 1));
        enter  = 1'($urandom_range(0, 1));
        case (op)
          2:  step("add",  5,  1, M_AL);
          3:  step("sub",  6,  1, M_AL | M_SUB);
          5:  step("jz",   8,  1, M_JMX | (aq ? M_PCL : 13'd0));
          6:  step("jpos", 9,  1, M_JMX | (ap ? M_PCL : 13'd0));
          8:  step("jmp",  11, 1, M_JMX | M_PCL);
          9:  step("jnz",  12, 1, M_JMX | (aq ? 13'd0 : M_PCL));
          10: step("ldi",  13, 1, M_AL | AS_IMM);
          default: step("nop", 14, 1, '0);
        endcase
      end
    endcase
    m_cnt++;
  endtask

  task automatic run_term(input int op);
    int es;
    fetch_decode(op, $urandom_range(0, 2));
    es = exec_state(op);
    for (int k = 0; k < 20; k++) begin
      memrdy = 1'($urandom_range(0, 1));
      enter  = 1'($urandom_range(0, 1));
      aeq0   = 1'($urandom_range(0, 1));
      step("term", es, es, (es == 15) ? (M_H | M_IL) : M_H);
    end
    check_counts("term");
  endtask

  initial begin
    int op;
    rst = 1'b1; ir = '0; aeq0 = 1'b0; apos = 1'b0; enter = 1'b0; memrdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(2, 0, 0, 0, 0);
    check_counts("after_add");
    run_instr(0, 4, 2, 0, 0);
    run_instr(4, 0, 6, 0, 0);
    for (int a = 0; a < 2; a++)
      for (int p = 0; p < 2; p++) begin
        run_instr(5, 0, 0, a[0], p[0]);
        run_instr(9, 0, 0, a[0], p[0]);
        run_instr(6, 0, 0, a[0], p[0]);
        run_instr(8, 0, 0, a[0], p[0]);
      end

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 11);
      if (op == 7) op = 11;
      run_instr(op, $urandom_range(0, 3), (op == 4) ? $urandom_range(0, 8) : $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check_counts("random_end");

    do_reset();
    for (int i = 0; i < 17; i++) run_instr(11, 0, 0, 0, 0);
    chk("wrap4", {28'd0, d4_cnt}, 1);
    chk("cnt17", {16'd0, cnt}, 17);

    do_reset();
    run_instr(2, 0, 0, 0, 0);
    run_term(7);
    do_reset();
    run_term(13);
    do_reset();
    run_term(12 + $urandom_range(0, 3));

    // Reset in the middle of a stalled STORE.
    do_reset();
    run_instr(3, 0, 0, 0, 0);
    fetch_decode(1, 0);
    memrdy = 1'b0;
    step("store_wait", 4, 4, M_MR | M_MW);
    #2;
    chk("pre_rst/req", {31'd0, memreq}, 1);
    chk("pre_rst/wr",  {31'd0, memwr},  1);
    rst = 1'b1;
    #1;
    chk("mid_rst/state", {28'd0, state}, 0);
    chk("mid_rst/req",   {31'd0, memreq}, 0);
    chk("mid_rst/wr",    {31'd0, memwr},  0);
    chk("mid_rst/cnt",   {16'd0, cnt},    0);
    chk("mid_rst/cnt4",  {28'd0, d4_cnt}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = 0;
    step("start2", 0, 1, '0);
    run_instr(10, 1, 0, 0, 0);
    check_counts("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
